// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request/grant/read-return ports.
// master = requesters (core load/store path and debug loader), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) ();
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt1, rvalid1, rdata1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt1, rvalid1, rdata1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter: port 0 (core) has fixed priority, port 1 (loader)
// gets starvation-forced grants and lockable bursts bounded by a forced yield.
module dmem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_LIMIT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_LIMIT + 1);

  typedef enum logic [1:0] {ARB, LOCK1, YIELD} state_t;

  state_t            state;
  logic [SW-1:0]     starve_cnt;
  logic [LW-1:0]     lock_cnt;
  logic              gnt0, gnt1;
  logic              acc0, acc1, acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              vld0_p1, vld1_p1;
  logic              vld0_p2, vld1_p2;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        ARB: begin
          gnt1 = bus.req1 && ((starve_cnt == SW'(STARVE_LIMIT)) || !bus.req0);
          gnt0 = bus.req0 && !gnt1;
        end
        LOCK1:   gnt1 = bus.req1;
        YIELD:   gnt0 = bus.req0;
        default: ;
      endcase
    end
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign acc0     = bus.req0 & gnt0;
  assign acc1     = bus.req1 & gnt1;
  assign acc      = acc0 | acc1;

  assign sel_we    = acc1 ? bus.we1    : bus.we0;
  assign sel_addr  = acc1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = acc1 ? bus.wdata1 : bus.wdata0;

  // lock_cnt counts port-1 accepts in the current burst, including the one that opened it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      if (!bus.req1 || acc1)
        starve_cnt <= '0;
      else if (state != LOCK1)
        starve_cnt <= sat_inc(starve_cnt);

      case (state)
        ARB: begin
          if (acc1 && bus.lock1) begin
            lock_cnt <= LW'(1);
            state    <= (LOCK_LIMIT == 1) ? YIELD : LOCK1;
          end
        end
        LOCK1: begin
          if (acc1) begin
            if (lock_cnt == LW'(LOCK_LIMIT - 1)) begin
              state    <= YIELD;
              lock_cnt <= '0;
            end else if (!bus.lock1) begin
              state    <= ARB;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end else if (!bus.req1) begin
            state    <= ARB;
            lock_cnt <= '0;
          end
        end
        YIELD: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
        default: state <= ARB;
      endcase
    end
  end

  // p1: SRAM command cycle; p2: SRAM read data on Q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      CEN     <= 1'b1;
      WEN     <= 1'b1;
      OEN     <= 1'b1;
      A       <= '0;
      D       <= '0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      vld0_p2 <= 1'b0;
      vld1_p2 <= 1'b0;
    end else begin
      CEN <= !acc;
      WEN <= !(acc && sel_we);
      OEN <= !(acc && !sel_we);
      if (acc) begin
        A <= sel_addr;
        D <= sel_wdata;
      end
      vld0_p1 <= acc0 && !bus.we0;
      vld1_p1 <= acc1 && !bus.we1;
      vld0_p2 <= vld0_p1;
      vld1_p2 <= vld1_p1;
    end
  end

  assign bus.rvalid0 = vld0_p2;
  assign bus.rvalid1 = vld1_p2;
  assign bus.rdata0  = vld0_p2 ? Q : '0;
  assign bus.rdata1  = vld1_p2 ? Q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model and an SRAM model.
module tb_dmem_arbiter;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_LIMIT   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cen, wen, oen;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q = '0;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .LOCK_LIMIT(LOCK_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d), .Q(q)
  );

  always #5 clk = ~clk;

  // SRAM macro behaviour: synchronous write, registered read data
  logic [DATA_W-1:0] sram [0:127];
  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) sram[a] <= d;
      else      q <= sram[a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit port; int due; logic [31:0] data; } ret_t;
  ret_t              rq[$];
  logic [31:0]       refmem [0:127];
  bit                m_ok = 0, m_locked = 0, m_yield = 0;
  int                m_burst = 0, m_wait = 0, cyc = 0;
  logic              e_cen, e_wen, e_oen;
  logic [ADDR_W-1:0] e_a;
  logic [DATA_W-1:0] e_d;

  always @(negedge clk) begin
    logic g0, g1, a0, a1, we;
    logic [31:0] rv0, rv1, rd0, rd1;
    logic [ADDR_W-1:0] ad;
    if (m_ok) begin
      chk("CEN", cen, e_cen);
      chk("WEN", wen, e_wen);
      chk("OEN", oen, e_oen);
      chk("A", a, e_a);
      chk("D", d, e_d);
      rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;
      foreach (rq[i]) if (rq[i].due == cyc) begin
        if (rq[i].port) begin rv1 = 1; rd1 = rq[i].data; end
        else            begin rv0 = 1; rd0 = rq[i].data; end
      end
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      chk("rvalid0", bus.rvalid0, rv0);
      chk("rvalid1", bus.rvalid1, rv1);
      chk("rdata0", bus.rdata0, rd0);
      chk("rdata1", bus.rdata1, rd1);
    end
    if (!rst_n) begin g0 = 0; g1 = 0; end
    else if (m_yield)  begin g0 = bus.req0; g1 = 0; end
    else if (m_locked) begin g0 = 0; g1 = bus.req1; end
    else begin
      g1 = bus.req1 && (m_wait >= STARVE_LIMIT || !bus.req0);
      g0 = bus.req0 && !g1;
    end
    chk("gnt0", bus.gnt0, g0);
    chk("gnt1", bus.gnt1, g1);

    if (!rst_n) begin
      m_ok = 1; m_locked = 0; m_yield = 0; m_burst = 0; m_wait = 0;
      e_cen = 1; e_wen = 1; e_oen = 1; e_a = 0; e_d = 0;
      rq.delete();
    end else begin
      a0 = bus.req0 & g0;
      a1 = bus.req1 & g1;
      if (a0 || a1) begin
        we = a1 ? bus.we1 : bus.we0;
        ad = a1 ? bus.addr1 : bus.addr0;
        e_cen = 0; e_wen = !we; e_oen = we; e_a = ad;
        e_d = a1 ? bus.wdata1 : bus.wdata0;
        if (we) refmem[ad] = e_d;
        else    rq.push_back('{port: a1, due: cyc + 2, data: refmem[ad]});
      end else begin
        e_cen = 1; e_wen = 1; e_oen = 1;
      end
      if (!bus.req1 || a1) m_wait = 0;
      else if (!m_locked && m_wait < STARVE_LIMIT) m_wait++;
      if (m_yield) m_yield = 0;
      else if (m_locked) begin
        if (a1) begin
          m_burst++;
          if (m_burst == LOCK_LIMIT) begin m_locked = 0; m_yield = 1; m_burst = 0; end
          else if (!bus.lock1)       begin m_locked = 0; m_burst = 0; end
        end else if (!bus.req1) begin m_locked = 0; m_burst = 0; end
      end else if (a1 && bus.lock1) begin
        m_burst = 1;
        if (LOCK_LIMIT == 1) begin m_yield = 1; m_burst = 0; end
        else m_locked = 1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] raddr();
    return ($urandom_range(0, 19) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
  endfunction

  task automatic idle_ports();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.lock1 = 0;
  endtask

  task automatic wait_gnt1(input string nm, input int exp_wait);
    int w = 0;
    @(negedge clk);
    while (!bus.gnt1 && w < 12) begin
      tick();
      w++;
      @(negedge clk);
    end
    chk(nm, w, exp_wait);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic a0s, a1s;
    for (int i = 0; i < 128; i++) refmem[i] = '0;
    idle_ports();
    rst_n = 0;
    bus.req0 = 1; bus.req1 = 1;

    // reset held two cycles with both ports requesting
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_CEN", cen, 1);
      chk("rst_WEN", wen, 1);
      chk("rst_OEN", oen, 1);
      chk("rst_A", a, 0);
      chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
      tick();
    end
    rst_n = 1;
    idle_ports();

    // preload the working address set with back-to-back port-0 writes
    for (int k = 0; k <= 16; k++) begin
      bus.req0 = 1; bus.we0 = 1;
      bus.addr0 = (k == 16) ? 7'd127 : 7'(k);
      bus.wdata0 = $urandom;
      @(negedge clk);
      chk("preload_gnt0", bus.gnt0, 1);
      tick();
    end
    idle_ports();
    tick();

    // single write then read of address 5
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5; bus.wdata0 = 32'hDEADBEEF;
    @(negedge clk); chk("wr_gnt0", bus.gnt0, 1);
    tick(); idle_ports();
    @(negedge clk);
    chk("wr_CEN", cen, 0); chk("wr_WEN", wen, 0); chk("wr_OEN", oen, 1);
    chk("wr_A", a, 5);     chk("wr_D", d, 32'hDEADBEEF);
    tick();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5;
    @(negedge clk); chk("rd_gnt0", bus.gnt0, 1);
    tick(); idle_ports();
    @(negedge clk);
    chk("rd_CEN", cen, 0); chk("rd_WEN", wen, 1); chk("rd_OEN", oen, 0);
    chk("rd_rvalid_early", bus.rvalid0, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid0", bus.rvalid0, 1);
    chk("rd_rdata0", bus.rdata0, 32'hDEADBEEF);
    tick();
    @(negedge clk); chk("rd_rvalid_once", bus.rvalid0, 0);
    tick();

    // starvation: both ports request continuously -> 4x gnt0 then 1x gnt1
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("starve_gnt0", bus.gnt0, (k % 5) != 4);
      chk("starve_gnt1", bus.gnt1, (k % 5) == 4);
      tick();
    end
    idle_ports();
    repeat (3) tick();

    // lock burst of three accesses (lock1 = 1,1,0) against a busy port 0
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4; bus.wdata1 = 32'h1234_5678; bus.lock1 = 1;
    wait_gnt1("lock_wait", STARVE_LIMIT);
    tick();
    @(negedge clk); chk("lock_b2_gnt1", bus.gnt1, 1); chk("lock_b2_gnt0", bus.gnt0, 0);
    tick(); bus.lock1 = 0;
    @(negedge clk); chk("lock_b3_gnt1", bus.gnt1, 1); chk("lock_b3_gnt0", bus.gnt0, 0);
    tick(); bus.req1 = 0;
    @(negedge clk); chk("lock_after_gnt0", bus.gnt0, 1);
    tick();
    idle_ports();
    repeat (3) tick();

    // lock limit: lock1 held high -> 8 port-1 accepts, a yield, then arbitration
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7; bus.lock1 = 1;
    wait_gnt1("limit_wait", STARVE_LIMIT);
    for (int k = 0; k < LOCK_LIMIT; k++) begin
      if (k > 0) begin tick(); @(negedge clk); end
      chk("limit_gnt1", bus.gnt1, 1);
      chk("limit_gnt0", bus.gnt0, 0);
    end
    tick();
    @(negedge clk); chk("yield_gnt0", bus.gnt0, 1); chk("yield_gnt1", bus.gnt1, 0);
    tick();
    @(negedge clk); chk("resume_gnt0", bus.gnt0, 1); chk("resume_gnt1", bus.gnt1, 0);
    tick();
    idle_ports();
    repeat (3) tick();

    // reset arriving while a port-1 read is in flight
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 9;
    @(negedge clk); chk("midrst_gnt1", bus.gnt1, 1);
    tick();
    idle_ports(); rst_n = 0;
    @(negedge clk); chk("midrst_gnt_off", {bus.gnt0, bus.gnt1}, 0);
    tick();
    @(negedge clk);
    chk("midrst_rvalid1", bus.rvalid1, 0);
    chk("midrst_CEN", cen, 1); chk("midrst_WEN", wen, 1); chk("midrst_OEN", oen, 1);
    chk("midrst_A", a, 0);     chk("midrst_D", d, 0);
    tick(); rst_n = 1;
    @(negedge clk); chk("midrst_rvalid1_late", bus.rvalid1, 0);
    tick();

    // random traffic; requests held until accepted, occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a0s = bus.req0 & bus.gnt0;
      a1s = bus.req1 & bus.gnt1;
      tick();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 599) == 0) rst_n = 0;
      if (!bus.req0 || a0s) begin
        bus.req0 = ($urandom_range(0, 9) < 7); bus.we0 = 1'($urandom_range(0, 1));
        bus.addr0 = raddr(); bus.wdata0 = $urandom;
      end
      if (!bus.req1 || a1s) begin
        bus.req1 = ($urandom_range(0, 9) < 7); bus.we1 = 1'($urandom_range(0, 1));
        bus.addr1 = raddr(); bus.wdata1 = $urandom;
        bus.lock1 = ($urandom_range(0, 3) != 0);
      end
    end
    rst_n = 1;
    idle_ports();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
